dds_sequencer: RTL and testbench

DDS_SEQUENCER -- requirements
Module: dds_sequencer

---
 rtl/dds_pkg.sv | 53 +++++
 rtl/dds_shaper.sv | 81 ++++++++
 rtl/dds_sequencer.sv | 135 +++++++++++++
 tb/tb_dds_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types, constants and helpers for the DDS sequencer and its waveform shaper.
package dds_pkg;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_t;

  localparam int FREQ_W    = 20;
  localparam int ROM_AW    = 11;
  localparam int DIGIT_MAX = 5;
  localparam logic [7:0]        MIDSCALE = 8'h80;
  localparam logic [FREQ_W-1:0] FREQ_MAX = '1;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_ENTER = 4;

  typedef struct packed {
    logic       valid;
    wave_t      wave;
    logic [1:0] amp;
    logic [7:0] shape;
  } stage_t;

  // Decimal step table indexed by the selected digit.
  function automatic logic [FREQ_W-1:0] step_of(input logic [2:0] digit);
    case (digit)
      3'd0:    return 20'd1;
      3'd1:    return 20'd10;
      3'd2:    return 20'd100;
      3'd3:    return 20'd1000;
      3'd4:    return 20'd10000;
      3'd5:    return 20'd100000;
      default: return 20'd0;
    endcase
  endfunction

  // Attenuate around midscale; the offset term keeps the sum inside 8 bits.
  function automatic logic [7:0] scale(input logic [7:0] s, input logic [1:0] amp);
    return (s >> amp) + (MIDSCALE - (MIDSCALE >> amp));
  endfunction

endpackage

// File: rtl/dds_shaper.sv
// Waveform select, alignment of the computed waveforms to the sine ROM latency,
// and amplitude scaling onto the registered DAC sample.
module dds_shaper
  import dds_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_flush,
  input  logic       i_valid,
  input  logic [8:0] i_phase_top,
  input  logic [1:0] i_wave,
  input  logic [1:0] i_amp,
  input  logic [7:0] i_rom_q,
  output logic [7:0] o_dac_value,
  output logic       o_dac_valid
);

  // Two stages match the rom_addr register plus the one-cycle ROM read.
  localparam int ALIGN = 2;

  stage_t     w_stage_in;
  stage_t     w_last;
  wave_t      w_wave_in;
  logic [7:0] w_tri;
  logic [7:0] w_sample;
  logic [7:0] r_dac_value;
  logic       r_dac_valid;

  always_comb begin
    w_wave_in        = wave_t'(i_wave);
    w_tri            = i_phase_top[7:0];
    w_stage_in       = '0;
    w_stage_in.valid = i_valid;
    w_stage_in.wave  = w_wave_in;
    w_stage_in.amp   = i_amp;
    case (w_wave_in)
      WAVE_SQUARE: w_stage_in.shape = {8{i_phase_top[8]}};
      WAVE_TRI:    w_stage_in.shape = i_phase_top[8] ? ~w_tri : w_tri;
      WAVE_SAW:    w_stage_in.shape = i_phase_top[8:1];
      default:     w_stage_in.shape = 8'h00;
    endcase
  end

  for (genvar gi = 0; gi < ALIGN; gi++) begin : g_align
    stage_t w_prev;
    stage_t r_q;
    if (gi == 0) begin : g_first
      assign w_prev = w_stage_in;
    end else begin : g_rest
      assign w_prev = g_align[gi-1].r_q;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     r_q <= '0;
      else if (i_flush) r_q <= '0;
      else              r_q <= w_prev;
    end
  end

  assign w_last = g_align[ALIGN-1].r_q;

  always_comb begin
    w_sample = (w_last.wave == WAVE_SINE) ? i_rom_q : w_last.shape;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dac_value <= MIDSCALE;
      r_dac_valid <= 1'b0;
    end else if (i_flush) begin
      r_dac_value <= MIDSCALE;
      r_dac_valid <= 1'b0;
    end else begin
      r_dac_valid <= w_last.valid;
      if (w_last.valid) r_dac_value <= scale(w_sample, w_last.amp);
    end
  end

  assign o_dac_value = r_dac_value;
  assign o_dac_valid = r_dac_valid;

endmodule

// File: rtl/dds_sequencer.sv
// DDS tone sequencer: sample tick, STOP/RUN control, phase accumulator,
// key-driven tuning word editing and the sine ROM address.
module dds_sequencer
  import dds_pkg::*;
#(
  parameter int SAMPLE_DIV = 500,
  parameter int PHASE_W    = 24,
  parameter int FREQ_RESET = 168
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [4:0]        i_key_pulse,
  input  logic [1:0]        i_wave_sel,
  input  logic [1:0]        i_amp_shift,
  input  logic [7:0]        i_rom_q,
  output logic [ROM_AW-1:0] o_rom_addr,
  output logic [7:0]        o_dac_value,
  output logic              o_dac_valid,
  output logic [FREQ_W-1:0] o_freq_word,
  output logic [2:0]        o_digit_sel,
  output logic              o_running
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  state_t              r_state, w_state_next;
  logic [CNT_W-1:0]    r_tick_cnt;
  logic                w_tick, w_sample, w_stop_now;
  logic                w_enter, w_up, w_down, w_left, w_right;
  logic [PHASE_W-1:0]  r_phase;
  logic                r_phase_valid;
  logic [1:0]          r_wave, r_amp;
  logic [FREQ_W-1:0]   r_freq_word, w_step, w_freq_dn;
  logic [FREQ_W:0]     w_freq_sum;
  logic [2:0]          r_digit_sel;
  logic [ROM_AW-1:0]   r_rom_addr;

  // Only the highest-priority key acts: enter > up > down > left > right.
  always_comb begin
    w_enter = i_key_pulse[KEY_ENTER];
    w_up    = i_key_pulse[KEY_UP] & ~w_enter;
    w_down  = i_key_pulse[KEY_DOWN] & ~w_enter & ~i_key_pulse[KEY_UP];
    w_left  = i_key_pulse[KEY_LEFT] & ~w_enter & ~i_key_pulse[KEY_UP] & ~i_key_pulse[KEY_DOWN];
    w_right = i_key_pulse[KEY_RIGHT] & ~w_enter & ~i_key_pulse[KEY_UP] & ~i_key_pulse[KEY_DOWN]
              & ~i_key_pulse[KEY_LEFT];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_STOP: if (w_enter) w_state_next = ST_RUN;
      ST_RUN:  if (w_enter) w_state_next = ST_STOP;
      default: w_state_next = ST_STOP;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_STOP;
    else          r_state <= w_state_next;
  end

  // A tick coincident with enter is judged against the state being entered.
  assign w_tick     = (r_tick_cnt == CNT_LAST);
  assign w_sample   = w_tick && (w_state_next == ST_RUN);
  assign w_stop_now = (r_state == ST_RUN) && (w_state_next == ST_STOP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_tick_cnt <= '0;
    else          r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase       <= '0;
      r_phase_valid <= 1'b0;
      r_wave        <= '0;
      r_amp         <= '0;
    end else begin
      r_phase_valid <= w_sample;
      if (w_stop_now) begin
        r_phase <= '0;
      end else if (w_sample) begin
        r_phase <= r_phase + PHASE_W'(r_freq_word);
        r_wave  <= i_wave_sel;
        r_amp   <= i_amp_shift;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           r_rom_addr <= '0;
    else if (r_phase_valid) r_rom_addr <= r_phase[PHASE_W-1 -: ROM_AW];
  end

  always_comb begin
    w_step     = step_of(r_digit_sel);
    w_freq_sum = {1'b0, r_freq_word} + {1'b0, w_step};
    w_freq_dn  = (r_freq_word >= w_step) ? (r_freq_word - w_step) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_freq_word <= FREQ_W'(FREQ_RESET);
      r_digit_sel <= '0;
    end else if (w_up) begin
      r_freq_word <= w_freq_sum[FREQ_W] ? FREQ_MAX : w_freq_sum[FREQ_W-1:0];
    end else if (w_down) begin
      r_freq_word <= w_freq_dn;
    end else if (w_left) begin
      r_digit_sel <= (r_digit_sel == '0) ? 3'(DIGIT_MAX) : r_digit_sel - 1'b1;
    end else if (w_right) begin
      r_digit_sel <= (r_digit_sel == 3'(DIGIT_MAX)) ? '0 : r_digit_sel + 1'b1;
    end
  end

  dds_shaper u_shaper (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (w_stop_now),
    .i_valid     (r_phase_valid),
    .i_phase_top (r_phase[PHASE_W-1 -: 9]),
    .i_wave      (r_wave),
    .i_amp       (r_amp),
    .i_rom_q     (i_rom_q),
    .o_dac_value (o_dac_value),
    .o_dac_valid (o_dac_valid)
  );

  assign o_rom_addr  = r_rom_addr;
  assign o_freq_word = r_freq_word;
  assign o_digit_sel = r_digit_sel;
  assign o_running   = (r_state == ST_RUN);

endmodule

// File: tb/tb_dds_sequencer.sv
// Scoreboard bench for dds_sequencer: a tick/phase reference model predicts each
// DAC sample; a negedge monitor matches every dac_valid strobe against it.
module tb_dds_sequencer;

  localparam int DIV = 8;
  localparam int PW  = 24;
  localparam int FR  = 168;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  key = '0;
  logic [1:0]  wave = '0;
  logic [1:0]  amp = '0;
  logic [7:0]  rom_q;
  logic [10:0] rom_addr;
  logic [7:0]  dac_value;
  logic        dac_valid;
  logic [19:0] freq_word;
  logic [2:0]  digit_sel;
  logic        running;

  logic [7:0]  rom_mem [2048];

  typedef struct {
    int due;
    int value;
    int addr;
  } exp_t;
  exp_t sbq[$];

  int  tests = 0;
  int  fails = 0;
  int  edge_n = 0;
  int  m_cnt = 0;
  int  m_phase = 0;
  int  m_fw = FR;
  int  m_digit = 0;
  int  m_samples = 0;
  bit  m_run = 1'b0;
  bit  m_new_run;
  bit  m_tick_now = 1'b0;
  int  prev_addr = -1;
  bit  wrap_seen = 1'b0;

  dds_sequencer #(.SAMPLE_DIV(DIV), .PHASE_W(PW), .FREQ_RESET(FR)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_key_pulse (key),
    .i_wave_sel  (wave),
    .i_amp_shift (amp),
    .i_rom_q     (rom_q),
    .o_rom_addr  (rom_addr),
    .o_dac_value (dac_value),
    .o_dac_valid (dac_valid),
    .o_freq_word (freq_word),
    .o_digit_sel (digit_sel),
    .o_running   (running)
  );

  always #10 clk = ~clk;

  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  function automatic void chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  function automatic int pow10(int d);
    int r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic int ref_sample(int w, int a, int ph);
    int s, msb, rem;
    msb = ph / (1 << 23);
    case (w)
      0:       s = int'(rom_mem[ph / (1 << 13)]);
      1:       s = (msb != 0) ? 255 : 0;
      2: begin rem = (ph / (1 << 15)) % 256; s = (msb != 0) ? 255 - rem : rem; end
      default: s = ph / (1 << 16);
    endcase
    return s / (1 << a) + 128 - 128 / (1 << a);
  endfunction

  // Reference model: one sample per tick in RUN, due three edges after the tick edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_phase = 0; m_fw = FR; m_digit = 0; m_run = 1'b0;
      m_tick_now = 1'b0;
      sbq.delete();
    end else begin
      edge_n++;
      m_tick_now = (m_cnt == DIV - 1);
      m_cnt = (m_cnt + 1) % DIV;
      m_new_run = key[4] ? !m_run : m_run;
      if (m_run && !m_new_run) begin
        m_phase = 0;
        sbq.delete();
      end
      if (m_tick_now && m_new_run) begin
        m_phase = (m_phase + m_fw) % (1 << PW);
        sbq.push_back('{edge_n + 3, ref_sample(int'(wave), int'(amp), m_phase), m_phase / (1 << 13)});
        m_samples++;
      end
      if (!key[4]) begin
        if (key[0])      m_fw = (m_fw + pow10(m_digit) > 20'hFFFFF) ? 20'hFFFFF : m_fw + pow10(m_digit);
        else if (key[1]) m_fw = (m_fw < pow10(m_digit)) ? 0 : m_fw - pow10(m_digit);
        else if (key[2]) m_digit = (m_digit + 5) % 6;
        else if (key[3]) m_digit = (m_digit + 1) % 6;
      end
      m_run = m_new_run;
    end
  end

  // Monitor: control outputs every cycle, samples whenever dac_valid strobes.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_dac_value", dac_value, 8'h80);
      chk("rst_dac_valid", dac_valid, 0);
      chk("rst_freq_word", freq_word, FR);
      chk("rst_digit_sel", digit_sel, 0);
      chk("rst_running", running, 0);
      chk("rst_rom_addr", rom_addr, 0);
    end else begin
      chk("freq_word", freq_word, m_fw);
      chk("digit_sel", digit_sel, m_digit);
      chk("running", running, m_run);
      while (sbq.size() > 0 && sbq[0].due < edge_n) begin
        chk("dac_valid_missing", 0, 1);
        void'(sbq.pop_front());
      end
      if (dac_valid) begin
        if (sbq.size() > 0 && sbq[0].due == edge_n) begin
          chk("dac_value", dac_value, sbq[0].value);
          chk("rom_addr", rom_addr, sbq[0].addr);
          if (prev_addr == 2047 && rom_addr == 11'd0) wrap_seen = 1'b1;
          prev_addr = int'(rom_addr);
          void'(sbq.pop_front());
        end else begin
          chk("dac_valid_unexpected", 1, 0);
        end
      end else if (sbq.size() > 0 && sbq[0].due == edge_n) begin
        chk("dac_valid_late", 0, 1);
        void'(sbq.pop_front());
      end
      if (!m_run && sbq.size() == 0) chk("stop_dac_value", dac_value, 8'h80);
    end
  end

  task automatic press(input logic [4:0] k);
    key = k;
    @(negedge clk);
    key = '0;
  endtask

  task automatic press_n(input logic [4:0] k, input int n);
    for (int i = 0; i < n; i++) press(k);
  endtask

  task automatic wait_samples(input int n, input bit rand_amp);
    int target = m_samples + n;
    int budget = n * DIV + 4 * DIV;
    while (m_samples < target && budget > 0) begin
      if (rand_amp) amp = 2'($urandom_range(0, 3));
      @(negedge clk);
      budget--;
    end
    if (m_samples < target) chk("wait_samples_timeout", m_samples, target);
  endtask

  task automatic wait_tick_run();
    int budget = 4 * DIV;
    while (!(m_tick_now && m_run) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!(m_tick_now && m_run)) chk("wait_tick_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] k;
    for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom_range(0, 255));
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Five ticks at the reset tuning word accumulate 5*168.
    @(negedge clk);
    wave = 2'd3; amp = 2'd0;
    press(5'b10000);
    wait_samples(5, 1'b0);
    chk("phase_after_5_ticks", dut.r_phase, 840);
    repeat (4) @(negedge clk);
    press(5'b10000);
    chk("phase_after_stop", dut.r_phase, 0);

    // Top digit, saturate up; 16 ticks of 0xFFFFF put phase MSBs at 0xFF.
    press(5'b00100);
    chk("digit_wrap_left", digit_sel, 5);
    press_n(5'b00001, 11);
    chk("freq_sat_high", freq_word, 20'hFFFFF);
    wave = 2'd3; amp = 2'd3;
    press(5'b10000);
    wait_samples(16, 1'b0);
    repeat (4) @(negedge clk);
    chk("saw_amp3_top", dac_value, 8'h8F);
    press(5'b10000);
    press_n(5'b00010, 20);
    chk("freq_sat_low", freq_word, 0);

    // Up and down together: up wins.
    press_n(5'b01000, 3);
    chk("digit_wrap_right", digit_sel, 2);
    press(5'b00011);
    chk("up_beats_down", freq_word, 100);

    // Build 8192 = 2^13 so rom_addr steps by one per tick.
    press(5'b00010);
    press(5'b01000);
    press_n(5'b00001, 8);
    press(5'b00100); press(5'b00001);
    press(5'b00100); press_n(5'b00001, 9);
    press(5'b00100); press_n(5'b00001, 2);
    chk("freq_2pow13", freq_word, 8192);
    wave = 2'd0;
    prev_addr = -1; wrap_seen = 1'b0;
    press(5'b10000);
    wait_samples(2050, 1'b1);
    repeat (4) @(negedge clk);
    chk("rom_addr_wrapped", wrap_seen, 1);

    // Stop one clock after a tick: the in-flight sample must vanish.
    wait_tick_run();
    press(5'b10000);
    chk("stop_phase_zero", dut.r_phase, 0);
    chk("stop_midscale", dac_value, 8'h80);
    repeat (6) @(negedge clk);

    // Randomized keys, waveforms and attenuation.
    press(5'b10000);
    for (int c = 0; c < 3000; c++) begin
      wave = 2'($urandom_range(0, 3));
      amp  = 2'($urandom_range(0, 3));
      k = 5'($urandom);
      if ($urandom_range(0, 7) != 0) k = '0;
      else if ($urandom_range(0, 15) != 0) k[4] = 1'b0;
      key = k;
      @(negedge clk);
    end
    key = '0;

    // Reset with a sample in flight: nothing may emerge afterwards.
    if (!m_run) press(5'b10000);
    wait_tick_run();
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    chk("post_reset_running", running, 0);
    press(5'b10000);
    wait_samples(3, 1'b1);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
